// File: rtl/int_rr_read_port_arbiter.sv
// Integer register-read port arbiter: shares NUM_READ_PORTS physical-register-file read
// ports among issue lanes with all-or-nothing grants, rotating priority and starvation forcing.
module int_rr_read_port_arbiter #(
  parameter  int NUM_LANES          = 2,
  parameter  int NUM_READ_PORTS     = 3,
  parameter  int PREG_NUM_BIT_WIDTH = 7,
  parameter  int STARVE_LIMIT       = 4,
  localparam int PTR_W  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int PORT_W = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1,
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               stall,
  input  logic [NUM_LANES-1:0]                               laneValid,
  input  logic [NUM_LANES-1:0]                               laneFlush,
  input  logic [NUM_LANES-1:0]                               needRegA,
  input  logic [NUM_LANES-1:0]                               needRegB,
  input  logic [NUM_LANES-1:0][PREG_NUM_BIT_WIDTH-1:0]       srcRegNumA,
  input  logic [NUM_LANES-1:0][PREG_NUM_BIT_WIDTH-1:0]       srcRegNumB,
  output logic [NUM_LANES-1:0]                               laneGrant,
  output logic [NUM_LANES-1:0]                               laneReplay,
  output logic [NUM_LANES-1:0][PORT_W-1:0]                   lanePortA,
  output logic [NUM_LANES-1:0][PORT_W-1:0]                   lanePortB,
  output logic [NUM_READ_PORTS-1:0]                          portValid,
  output logic [NUM_READ_PORTS-1:0][PREG_NUM_BIT_WIDTH-1:0]  portRegNum,
  output logic [31:0]                                        conflictCount
);

  logic [PTR_W-1:0]                rr_ptr;
  logic [NUM_LANES-1:0][CNT_W-1:0] starve_cnt;

  logic [NUM_LANES-1:0]            req;
  logic [NUM_LANES-1:0][1:0]       need;
  logic                            forced_valid;
  logic [PTR_W-1:0]                forced_idx;
  logic                            last_valid;
  logic [PTR_W-1:0]                last_idx;
  logic                            blocked;
  logic [PORT_W-1:0]               next_port;
  logic [PTR_W-1:0]                lane;
  int                              remaining;
  int                              start;
  int                              slot;
  int                              granted_need;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      req[i]  = laneValid[i] & ~laneFlush[i];
      need[i] = {1'b0, needRegA[i]} + {1'b0, needRegB[i]};
    end
  end

  // Descending scan so the lowest-index saturated lane wins.
  always_comb begin
    forced_valid = 1'b0;
    forced_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (starve_cnt[i] == CNT_W'(STARVE_LIMIT)) begin
        forced_valid = 1'b1;
        forced_idx   = PTR_W'(i);
      end
    end
  end

  // NOTE: every output of this block gets a default before the loop; otherwise
  // lanes or ports not touched on some path would infer latches.
  always_comb begin
    laneGrant    = '0;
    lanePortA    = '0;
    lanePortB    = '0;
    portValid    = '0;
    portRegNum   = '0;
    last_valid   = 1'b0;
    last_idx     = '0;
    blocked      = 1'b0;
    next_port    = '0;
    lane         = '0;
    remaining    = NUM_READ_PORTS;
    granted_need = 0;
    start        = forced_valid ? int'(forced_idx) : int'(rr_ptr);
    for (int k = 0; k < NUM_LANES; k++) begin
      slot = start + k;
      if (slot >= NUM_LANES) slot = slot - NUM_LANES;
      lane = PTR_W'(slot);
      if (req[lane]) begin
        if (need[lane] == 2'd0) begin
          laneGrant[lane] = 1'b1;
        end else if (!blocked && int'(need[lane]) <= remaining) begin
          laneGrant[lane] = 1'b1;
          remaining       = remaining - int'(need[lane]);
          granted_need    = granted_need + int'(need[lane]);
          last_valid      = 1'b1;
          last_idx        = lane;
          if (needRegA[lane]) begin
            lanePortA[lane]       = next_port;
            portValid[next_port]  = 1'b1;
            portRegNum[next_port] = srcRegNumA[lane];
            next_port             = next_port + 1'b1;
          end
          if (needRegB[lane]) begin
            lanePortB[lane]       = next_port;
            portValid[next_port]  = 1'b1;
            portRegNum[next_port] = srcRegNumB[lane];
            next_port             = next_port + 1'b1;
          end
        end else if (forced_valid && lane == forced_idx) begin
          // An unsatisfiable forced lane holds the ports back for its next attempt.
          blocked = 1'b1;
        end
      end
    end
  end

  assign laneReplay = req & ~laneGrant;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge combinational results; the comb block above uses blocking on purpose.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr        <= '0;
      starve_cnt    <= '0;
      conflictCount <= '0;
    end else if (!stall) begin
      if (last_valid) begin
        rr_ptr <= (last_idx == PTR_W'(NUM_LANES - 1)) ? '0 : last_idx + 1'b1;
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (laneGrant[i] || !req[i]) begin
          starve_cnt[i] <= '0;
        end else if (starve_cnt[i] != CNT_W'(STARVE_LIMIT)) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
      end
      if (|laneReplay && conflictCount != '1) begin
        conflictCount <= conflictCount + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (granted_need <= NUM_READ_PORTS);
      assert ((laneGrant & laneReplay) == '0);
      assert ($countones(portValid) == granted_need);
    end
  end

endmodule

// File: tb/tb_int_rr_read_port_arbiter.sv
// Directed bench for int_rr_read_port_arbiter: default 2-lane/3-port instance plus a
// 3-lane/2-port/limit-2 instance for starvation forcing; scoreboard queues per instance.
module tb_int_rr_read_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  // Default instance (2 lanes, 3 ports, limit 4)
  logic [1:0]      a_valid, a_flush, a_na, a_nb;
  logic [1:0][6:0] a_src_a, a_src_b;
  logic [1:0]      a_grant, a_replay;
  logic [1:0][1:0] a_lpa, a_lpb;
  logic [2:0]      a_pvalid;
  logic [2:0][6:0] a_preg;
  logic [31:0]     a_conflict;

  // Starvation instance (3 lanes, 2 ports, limit 2)
  logic [2:0]      b_valid, b_flush, b_na, b_nb;
  logic [2:0][6:0] b_src_a, b_src_b;
  logic [2:0]      b_grant, b_replay;
  logic [2:0][1:0] b_lpa, b_lpb;
  logic [1:0]      b_pvalid;
  logic [1:0][6:0] b_preg;
  logic [31:0]     b_conflict;

  int checks = 0;
  int errors = 0;

  int_rr_read_port_arbiter dut_a (
    .clk(clk), .rst(rst), .stall(stall),
    .laneValid(a_valid), .laneFlush(a_flush), .needRegA(a_na), .needRegB(a_nb),
    .srcRegNumA(a_src_a), .srcRegNumB(a_src_b),
    .laneGrant(a_grant), .laneReplay(a_replay), .lanePortA(a_lpa), .lanePortB(a_lpb),
    .portValid(a_pvalid), .portRegNum(a_preg), .conflictCount(a_conflict)
  );

  int_rr_read_port_arbiter #(
    .NUM_LANES(3), .NUM_READ_PORTS(2), .PREG_NUM_BIT_WIDTH(7), .STARVE_LIMIT(2)
  ) dut_b (
    .clk(clk), .rst(rst), .stall(stall),
    .laneValid(b_valid), .laneFlush(b_flush), .needRegA(b_na), .needRegB(b_nb),
    .srcRegNumA(b_src_a), .srcRegNumB(b_src_b),
    .laneGrant(b_grant), .laneReplay(b_replay), .lanePortA(b_lpa), .lanePortB(b_lpb),
    .portValid(b_pvalid), .portRegNum(b_preg), .conflictCount(b_conflict)
  );

  typedef struct packed {
    logic [1:0]      grant;
    logic [1:0]      replay;
    logic [2:0]      pvalid;
    logic [2:0][6:0] preg;
    logic [1:0][1:0] lpa;
    logic [1:0][1:0] lpb;
    logic [1:0]      na;
    logic [1:0]      nb;
    logic [31:0]     conflict;
  } exp_a_t;

  typedef struct packed {
    logic [2:0]      grant;
    logic [2:0]      replay;
    logic [1:0]      pvalid;
    logic [1:0][6:0] preg;
    logic [31:0]     conflict;
  } exp_b_t;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle on the default instance, compare at the falling edge, return after the next rise.
  task automatic step_a(input string tag, input logic [1:0] v, input logic [1:0] fl,
                        input logic [1:0] na, input logic [1:0] nb,
                        input logic [1:0] grant, input logic [1:0] replay,
                        input logic [2:0] pvalid, input logic [2:0][6:0] preg,
                        input logic [1:0][1:0] lpa, input logic [1:0][1:0] lpb,
                        input logic [31:0] conflict);
    exp_a_t e;
    a_valid = v; a_flush = fl; a_na = na; a_nb = nb;
    sb_a.push_back('{grant: grant, replay: replay, pvalid: pvalid, preg: preg,
                     lpa: lpa, lpb: lpb, na: na, nb: nb, conflict: conflict});
    @(negedge clk);
    e = sb_a.pop_front();
    check({tag, ".grant"},    64'(a_grant),    64'(e.grant));
    check({tag, ".replay"},   64'(a_replay),   64'(e.replay));
    check({tag, ".pvalid"},   64'(a_pvalid),   64'(e.pvalid));
    check({tag, ".preg"},     64'(a_preg),     64'(e.preg));
    check({tag, ".conflict"}, 64'(a_conflict), 64'(e.conflict));
    for (int i = 0; i < 2; i++) begin
      if (e.grant[i] && e.na[i]) check({tag, ".portA"}, 64'(a_lpa[i]), 64'(e.lpa[i]));
      if (e.grant[i] && e.nb[i]) check({tag, ".portB"}, 64'(a_lpb[i]), 64'(e.lpb[i]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input string tag, input logic [2:0] v,
                        input logic [2:0] grant, input logic [2:0] replay,
                        input logic [1:0] pvalid, input logic [1:0][6:0] preg,
                        input logic [31:0] conflict);
    exp_b_t e;
    b_valid = v;
    sb_b.push_back('{grant: grant, replay: replay, pvalid: pvalid, preg: preg, conflict: conflict});
    @(negedge clk);
    e = sb_b.pop_front();
    check({tag, ".grant"},    64'(b_grant),    64'(e.grant));
    check({tag, ".replay"},   64'(b_replay),   64'(e.replay));
    check({tag, ".pvalid"},   64'(b_pvalid),   64'(e.pvalid));
    check({tag, ".preg"},     64'(b_preg),     64'(e.preg));
    check({tag, ".conflict"}, 64'(b_conflict), 64'(e.conflict));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    a_valid = '0; a_flush = '0; a_na = '0; a_nb = '0;
    b_valid = '0; b_flush = '0; b_na = '0; b_nb = '0;
    a_src_a = {7'h21, 7'h11};
    a_src_b = {7'h22, 7'h12};
    b_src_a = {7'h32, 7'h31, 7'h30};
    b_src_b = {7'h42, 7'h41, 7'h40};

    #12;
    check("in_reset.grant",    64'(a_grant),    64'h0);
    check("in_reset.conflict", 64'(a_conflict), 64'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Conflicting traffic, then asynchronous reset mid-cycle.
    step_a("rst_c1", 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 3'b011,
           {7'h00, 7'h12, 7'h11}, {2'd0, 2'd0}, {2'd0, 2'd1}, 32'd0);
    step_a("rst_c2", 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 3'b011,
           {7'h00, 7'h22, 7'h21}, {2'd0, 2'd0}, {2'd1, 2'd0}, 32'd1);
    step_a("rst_c3", 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 3'b011,
           {7'h00, 7'h12, 7'h11}, {2'd0, 2'd0}, {2'd0, 2'd1}, 32'd2);
    check("pre_rst.conflict", 64'(a_conflict),     64'd3);
    check("pre_rst.rr_ptr",   64'(dut_a.rr_ptr),   64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst.rr_ptr",   64'(dut_a.rr_ptr),     64'd0);
    check("rst.starve",   64'(dut_a.starve_cnt), 64'd0);
    check("rst.conflict", 64'(a_conflict),       64'd0);
    a_valid = '0; a_na = '0; a_nb = '0;
    #2 rst = 1'b1;
    step_a("idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,
           '0, '0, '0, 32'd0);

    // Conflict rotation.
    step_a("rot_c1", 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 3'b011,
           {7'h00, 7'h12, 7'h11}, {2'd0, 2'd0}, {2'd0, 2'd1}, 32'd0);
    step_a("rot_c2", 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 3'b011,
           {7'h00, 7'h22, 7'h21}, {2'd0, 2'd0}, {2'd1, 2'd0}, 32'd1);

    // Mixed needs: both fit; conflictCount reflects the two rotation cycles.
    step_a("mixed", 2'b11, 2'b00, 2'b11, 2'b01, 2'b11, 2'b00, 3'b111,
           {7'h21, 7'h12, 7'h11}, {2'd2, 2'd0}, {2'd0, 2'd1}, 32'd2);

    // Flush of lane 0 hands lane 1 the low ports.
    step_a("flush", 2'b11, 2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 3'b011,
           {7'h00, 7'h22, 7'h21}, {2'd0, 2'd0}, {2'd1, 2'd0}, 32'd2);
    check("flush.starve0", 64'(dut_a.starve_cnt[0]), 64'd0);

    // Stall: grants keep flowing, state frozen.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_a("stall", 2'b11, 2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 3'b011,
             {7'h00, 7'h12, 7'h11}, {2'd0, 2'd0}, {2'd0, 2'd1}, 32'd2);
    end
    check("stall.rr_ptr", 64'(dut_a.rr_ptr),     64'd0);
    check("stall.starve", 64'(dut_a.starve_cnt), 64'd0);
    stall = 1'b0;
    step_a("post_stall", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000,
           '0, '0, '0, 32'd2);

    // Starvation forcing on the 3-lane/2-port instance.
    b_na = 3'b111;
    b_nb = 3'b100;
    step_b("starve_c1", 3'b101, 3'b001, 3'b100, 2'b01, {7'h00, 7'h30}, 32'd0);
    check("starve_c1.rr_ptr", 64'(dut_b.rr_ptr), 64'd1);
    step_b("starve_c2", 3'b111, 3'b011, 3'b100, 2'b11, {7'h30, 7'h31}, 32'd1);
    check("starve_c2.cnt2", 64'(dut_b.starve_cnt[2]), 64'd2);
    step_b("starve_c3", 3'b111, 3'b100, 3'b011, 2'b11, {7'h42, 7'h32}, 32'd2);
    check("starve_c3.cnt2",     64'(dut_b.starve_cnt[2]), 64'd0);
    check("starve_c3.conflict", 64'(b_conflict),          64'd3);
    b_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
